// File: rtl/jtag_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_types_pkg
//  Description : Shared types and constants for the JTAG DR packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_types_pkg;

  // Packer sequencing states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAUSE = 2'd2,
    FLUSH = 2'd3
  } packer_state_t;

  // Bit positions of the status word loaded into the shift register at Capture-DR.
  localparam int STAT_OVF     = 0;
  localparam int STAT_PART    = 1;
  localparam int STAT_CNT_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/jtag_dr_packer.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_dr_packer
//  Description : Packs TDI bits shifted during Shift-DR into WIDTH-bit words,
//                pushes them into the TCK-domain FIFO and reports drop status
//                on TDO after Capture-DR.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_dr_packer
  import jtag_types_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit PAD_PARTIAL = 1'b1
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             tdi,
  input  logic             fifo_full,
  input  logic             clr_status,
  output logic             wr_en,
  output logic [WIDTH-1:0] data_in,
  output logic             tdo,
  output logic             overflow,
  output logic             partial_drop,
  output logic [WIDTH-3:0] drop_cnt
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  packer_state_t    r_state;
  packer_state_t    w_next_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_last_bit;
  logic             w_flush;
  logic             w_has_partial;
  logic             w_pad_push;
  logic             w_part_drop;
  logic             w_push_req;
  logic             w_drop;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_padded;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_status;

  // The bit at the bottom of the shift register is always the one on the wire.
  assign tdo = r_sreg[0];

  // Next-state decode: shift_dr dominates, capture_dr returns to IDLE from anywhere.
  always_comb begin
    w_next_state = r_state;
    if (shift_dr) begin
      w_next_state = (r_state == FLUSH) ? IDLE : SHIFT;
    end else if (capture_dr) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = IDLE;
        SHIFT:   w_next_state = update_dr ? FLUSH : PAUSE;
        PAUSE:   w_next_state = update_dr ? FLUSH : PAUSE;
        FLUSH:   w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Per-cycle actions: word completion, partial-word flush, drop detection, status word.
  always_comb begin
    w_last_bit    = shift_dr && (r_bit_cnt == LAST_BIT);
    w_flush       = !shift_dr && !capture_dr && update_dr &&
                    ((r_state == SHIFT) || (r_state == PAUSE));
    w_has_partial = w_flush && (r_bit_cnt != '0);
    w_pad_push    = w_has_partial && PAD_PARTIAL;
    w_part_drop   = w_has_partial && !PAD_PARTIAL;
    w_push_req    = w_last_bit || w_pad_push;
    w_drop        = w_push_req && fifo_full;
    w_shifted     = {tdi, r_sreg[WIDTH-1:1]};
    // A partial word of n bits sits in the top n bits of the register; slide it
    // down to bit 0 so the stale bits fall off and zeros fill the top.
    w_padded      = r_sreg >> (WIDTH - int'(r_bit_cnt));
    w_word        = w_last_bit ? w_shifted : w_padded;
    w_status                             = '0;
    w_status[STAT_OVF]                   = overflow;
    w_status[STAT_PART]                  = partial_drop;
    w_status[WIDTH-1:STAT_CNT_LSB]       = drop_cnt;
  end

  // State, shift register, bit counter, FIFO push and sticky status.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_state      <= IDLE;
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      wr_en        <= 1'b0;
      data_in      <= '0;
      overflow     <= 1'b0;
      partial_drop <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      r_state <= w_next_state;
      wr_en   <= 1'b0;

      if (shift_dr) begin
        r_sreg    <= w_shifted;
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
      end else if (capture_dr) begin
        r_sreg    <= w_status;
        r_bit_cnt <= '0;
      end else if (w_flush) begin
        r_bit_cnt <= '0;
      end

      if (w_push_req && !fifo_full) begin
        wr_en   <= 1'b1;
        data_in <= w_word;
      end

      // Clearing wins over any set or increment landing in the same cycle.
      if (clr_status) begin
        overflow     <= 1'b0;
        partial_drop <= 1'b0;
        drop_cnt     <= '0;
      end else begin
        if (w_drop) begin
          overflow <= 1'b1;
          if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end
        if (w_part_drop) begin
          partial_drop <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_dr_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_dr_packer
//  Description : Self-checking bench for jtag_dr_packer (WIDTH=8), with one
//                instance padding partial words and one discarding them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_dr_packer;

  logic clk = 1'b0;
  logic rst, capture_dr, shift_dr, update_dr, tdi, fifo_full, clr_status;

  logic       pa_wr, pa_tdo, pa_ovf, pa_part;
  logic [7:0] pa_data;
  logic [5:0] pa_dcnt;
  logic       np_wr, np_tdo, np_ovf, np_part;
  logic [7:0] np_data;
  logic [5:0] np_dcnt;

  int checks   = 0;
  int failures = 0;

  // Reference model, index 0 = padding instance, 1 = discarding instance.
  int         m_nbits[2];
  logic [7:0] m_acc[2];
  bit         m_active[2];
  bit         m_ovf[2];
  bit         m_part[2];
  int         m_dcnt[2];
  bit         m_exp_wr[2];
  logic [7:0] m_exp_data[2];
  bit         m_ring[2][8];
  int         m_head[2];

  jtag_dr_packer #(.WIDTH(8), .PAD_PARTIAL(1'b1)) dut_pad (
    .TCK(clk), .TRST(rst), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .tdi(tdi), .fifo_full(fifo_full), .clr_status(clr_status),
    .wr_en(pa_wr), .data_in(pa_data), .tdo(pa_tdo), .overflow(pa_ovf),
    .partial_drop(pa_part), .drop_cnt(pa_dcnt)
  );

  jtag_dr_packer #(.WIDTH(8), .PAD_PARTIAL(1'b0)) dut_nopad (
    .TCK(clk), .TRST(rst), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .tdi(tdi), .fifo_full(fifo_full), .clr_status(clr_status),
    .wr_en(np_wr), .data_in(np_data), .tdo(np_tdo), .overflow(np_ovf),
    .partial_drop(np_part), .drop_cnt(np_dcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_nbits[k] = 0; m_acc[k] = '0; m_active[k] = 0; m_ovf[k] = 0; m_part[k] = 0;
      m_dcnt[k] = 0; m_exp_wr[k] = 0; m_exp_data[k] = '0; m_head[k] = 0;
      for (int i = 0; i < 8; i++) m_ring[k][i] = 0;
    end
  endtask

  // One TCK edge of behaviour, from the pre-edge inputs.
  task automatic model_edge(input int k, input bit sh, cap, upd, t, full, clr);
    bit         push_req = 0;
    bit         pdrop    = 0;
    logic [7:0] word     = '0;
    logic [7:0] st;
    st = {6'(m_dcnt[k]), m_part[k], m_ovf[k]};
    m_exp_wr[k] = 0;
    if (sh) begin
      m_acc[k][m_nbits[k]] = t;
      m_nbits[k]++;
      m_ring[k][m_head[k]] = t;
      m_head[k] = (m_head[k] + 1) % 8;
      m_active[k] = 1;
      if (m_nbits[k] == 8) begin
        push_req = 1; word = m_acc[k]; m_acc[k] = '0; m_nbits[k] = 0;
      end
    end else if (cap) begin
      for (int i = 0; i < 8; i++) m_ring[k][(m_head[k] + i) % 8] = st[i];
      m_nbits[k] = 0; m_acc[k] = '0; m_active[k] = 0;
    end else if (upd && m_active[k]) begin
      if (m_nbits[k] != 0) begin
        if (k == 0) begin push_req = 1; word = m_acc[k]; end
        else pdrop = 1;
      end
      m_nbits[k] = 0; m_acc[k] = '0; m_active[k] = 0;
    end
    if (push_req && !full) begin
      m_exp_wr[k] = 1; m_exp_data[k] = word;
    end
    if (clr) begin
      m_ovf[k] = 0; m_part[k] = 0; m_dcnt[k] = 0;
    end else begin
      if (push_req && full) begin
        m_ovf[k] = 1;
        if (m_dcnt[k] < 63) m_dcnt[k]++;
      end
      if (pdrop) m_part[k] = 1;
    end
  endtask

  task automatic check_all();
    chk("pad_wr_en",     pa_wr,   m_exp_wr[0]);
    chk("pad_data_in",   pa_data, m_exp_data[0]);
    chk("pad_overflow",  pa_ovf,  m_ovf[0]);
    chk("pad_partial",   pa_part, m_part[0]);
    chk("pad_drop_cnt",  pa_dcnt, m_dcnt[0]);
    chk("pad_tdo",       pa_tdo,  m_ring[0][m_head[0]]);
    chk("nopad_wr_en",   np_wr,   m_exp_wr[1]);
    chk("nopad_data_in", np_data, m_exp_data[1]);
    chk("nopad_overflow",np_ovf,  m_ovf[1]);
    chk("nopad_partial", np_part, m_part[1]);
    chk("nopad_drop_cnt",np_dcnt, m_dcnt[1]);
    chk("nopad_tdo",     np_tdo,  m_ring[1][m_head[1]]);
  endtask

  task automatic step(input bit sh, cap, upd, t, full, clr);
    shift_dr = sh; capture_dr = cap; update_dr = upd; tdi = t;
    fifo_full = full; clr_status = clr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, sh, cap, upd, t, full, clr);
    #1;
    check_all();
  endtask

  task automatic shift_byte(input logic [7:0] b, input bit full);
    for (int i = 0; i < 8; i++) step(1, 0, 0, b[i], full, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] tdo_seq;
    bit         prev_upd;
    bit         sh, cap, upd;
    rst = 1'b1; capture_dr = 0; shift_dr = 0; update_dr = 0; tdi = 0;
    fifo_full = 0; clr_status = 0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single word 0xA5, LSB first.
    shift_byte(8'hA5, 0);
    chk("a5_word", pa_data, 8'hA5);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Back-to-back words 0x3C then 0xFF.
    shift_byte(8'h3C, 0);
    chk("b2b_first", pa_data, 8'h3C);
    shift_byte(8'hFF, 0);
    chk("b2b_second", pa_data, 8'hFF);
    step(0, 0, 0, 0, 0, 0);

    // Two drops into a full FIFO, then read the status back on TDO.
    shift_byte(8'h55, 1);
    shift_byte(8'h55, 1);
    chk("full_dcnt", pa_dcnt, 6'd2);
    step(0, 1, 0, 0, 0, 0);
    tdo_seq = 8'b0000_1001;
    chk("status_tdo0", pa_tdo, tdo_seq[0]);
    for (int i = 1; i < 8; i++) begin
      step(1, 0, 0, 1'($urandom), 0, 0);
      chk("status_tdo", pa_tdo, tdo_seq[i]);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // Partial word 1,1,0 then Update-DR.
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("partial_pad_word", pa_data, 8'h03);
    chk("partial_nopad_flag", np_part, 1'b1);
    step(0, 0, 0, 0, 0, 0);

    // Reset after five bits, then a clean 0x81.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1'($urandom), 0, 0);
    mid_reset();
    shift_byte(8'h81, 0);
    chk("after_reset_word", pa_data, 8'h81);
    // Reset while a push is on the bus.
    shift_byte(8'h5A, 0);
    mid_reset();

    // Drop counter saturation, then clear coinciding with a drop.
    for (int w = 0; w < 70; w++) shift_byte(8'($urandom), 1);
    chk("sat_dcnt", pa_dcnt, 6'h3F);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1'($urandom), 1, 0);
    step(1, 0, 0, 1'($urandom), 1, 1);
    chk("clr_ovf", pa_ovf, 1'b0);
    chk("clr_dcnt", pa_dcnt, 6'h00);

    // Randomized traffic; no shift directly after an Update-DR cycle.
    prev_upd = 0;
    for (int n = 0; n < 400; n++) begin
      sh  = !prev_upd && ($urandom_range(0, 9) < 6);
      cap = ($urandom_range(0, 19) == 0);
      upd = ($urandom_range(0, 11) == 0);
      step(sh, cap, upd, 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0));
      prev_upd = upd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
